// File: rtl/frac_reduce.sv
// frac_reduce: reduces an unsigned fraction by the GCD returned from the
// external Euclidean core, using two sequential restoring dividers.
module frac_reduce #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_num,
    input  logic [WIDTH-1:0] in_den,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_num,
    output logic [WIDTH-1:0] out_den,
    output logic [WIDTH-1:0] out_gcd,
    output logic             out_err,
    output logic [WIDTH-1:0] gcd_opa,
    output logic [WIDTH-1:0] gcd_opb,
    output logic             gcd_start,
    input  logic [WIDTH-1:0] gcd_result,
    input  logic             gcd_done
);

    localparam int unsigned WCW = $clog2(TIMEOUT + 1);
    localparam int unsigned DCW = $clog2(WIDTH + 1);
    localparam int unsigned SW  = 2 * WIDTH + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DIV   = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;

    // One restoring-division step: returns {next partial remainder, next quotient/dividend}
    function automatic logic [SW-1:0] div_step(
        input logic [WIDTH:0]   rem,
        input logic [WIDTH-1:0] q,
        input logic [WIDTH-1:0] d
    );
        logic [WIDTH:0] sh;
        logic [WIDTH:0] dd;
        sh = (rem << 1) | {{WIDTH{1'b0}}, q[WIDTH-1]};
        dd = {1'b0, d};
        if (sh >= dd) begin
            div_step = {sh - dd, q[WIDTH-2:0], 1'b1};
        end else begin
            div_step = {sh, q[WIDTH-2:0], 1'b0};
        end
    endfunction

    logic [2:0]       r_state, w_state_nxt;
    logic             r_in_ready, w_in_ready_nxt;
    logic             r_out_valid, w_out_valid_nxt;
    logic             r_gcd_start, w_gcd_start_nxt;
    logic [WIDTH-1:0] r_num, w_num_nxt;
    logic [WIDTH-1:0] r_den, w_den_nxt;
    logic [WIDTH-1:0] r_g, w_g_nxt;
    logic [WCW-1:0]   r_wcnt, w_wcnt_nxt;
    logic [DCW-1:0]   r_dcnt, w_dcnt_nxt;
    logic [WIDTH:0]   r_rem_n, w_rem_n_nxt;
    logic [WIDTH:0]   r_rem_d, w_rem_d_nxt;
    logic [WIDTH-1:0] r_q_n, w_q_n_nxt;
    logic [WIDTH-1:0] r_q_d, w_q_d_nxt;
    logic [WIDTH-1:0] r_out_num, w_out_num_nxt;
    logic [WIDTH-1:0] r_out_den, w_out_den_nxt;
    logic [WIDTH-1:0] r_out_gcd, w_out_gcd_nxt;
    logic             r_out_err, w_out_err_nxt;
    logic [SW-1:0]    w_step_n;
    logic [SW-1:0]    w_step_d;

    assign w_step_n = div_step(r_rem_n, r_q_n, r_g);
    assign w_step_d = div_step(r_rem_d, r_q_d, r_g);

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_num   = r_out_num;
    assign out_den   = r_out_den;
    assign out_gcd   = r_out_gcd;
    assign out_err   = r_out_err;
    assign gcd_opa   = r_num;
    assign gcd_opb   = r_den;
    assign gcd_start = r_gcd_start;

    // Next-state and next-register values for the job sequencer and dividers
    always_comb begin
        w_state_nxt     = r_state;
        w_gcd_start_nxt = 1'b0;
        w_num_nxt       = r_num;
        w_den_nxt       = r_den;
        w_g_nxt         = r_g;
        w_wcnt_nxt      = r_wcnt;
        w_dcnt_nxt      = r_dcnt;
        w_rem_n_nxt     = r_rem_n;
        w_rem_d_nxt     = r_rem_d;
        w_q_n_nxt       = r_q_n;
        w_q_d_nxt       = r_q_d;
        w_out_num_nxt   = r_out_num;
        w_out_den_nxt   = r_out_den;
        w_out_gcd_nxt   = r_out_gcd;
        w_out_err_nxt   = r_out_err;

        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_num_nxt = in_num;
                    w_den_nxt = in_den;
                    if (in_den == '0) begin
                        w_state_nxt   = S_OUT;
                        w_out_num_nxt = in_num;
                        w_out_den_nxt = '0;
                        w_out_gcd_nxt = '0;
                        w_out_err_nxt = 1'b1;
                    end else if (in_num == '0) begin
                        w_state_nxt   = S_OUT;
                        w_out_num_nxt = '0;
                        w_out_den_nxt = WIDTH'(1);
                        w_out_gcd_nxt = in_den;
                        w_out_err_nxt = 1'b0;
                    end else begin
                        w_state_nxt     = S_ISSUE;
                        w_gcd_start_nxt = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
                w_wcnt_nxt  = '0;
            end
            S_WAIT: begin
                if (gcd_done) begin
                    w_state_nxt = S_DIV;
                    w_g_nxt     = gcd_result;
                    w_rem_n_nxt = '0;
                    w_rem_d_nxt = '0;
                    w_q_n_nxt   = r_num;
                    w_q_d_nxt   = r_den;
                    w_dcnt_nxt  = '0;
                end else if (r_wcnt == WCW'(TIMEOUT - 1)) begin
                    w_state_nxt   = S_OUT;
                    w_out_num_nxt = r_num;
                    w_out_den_nxt = r_den;
                    w_out_gcd_nxt = '0;
                    w_out_err_nxt = 1'b1;
                end else begin
                    w_wcnt_nxt = r_wcnt + WCW'(1);
                end
            end
            S_DIV: begin
                w_rem_n_nxt = w_step_n[SW-1:WIDTH];
                w_q_n_nxt   = w_step_n[WIDTH-1:0];
                w_rem_d_nxt = w_step_d[SW-1:WIDTH];
                w_q_d_nxt   = w_step_d[WIDTH-1:0];
                if (r_dcnt == DCW'(WIDTH - 1)) begin
                    w_state_nxt   = S_OUT;
                    w_out_num_nxt = w_step_n[WIDTH-1:0];
                    w_out_den_nxt = w_step_d[WIDTH-1:0];
                    w_out_gcd_nxt = r_g;
                    w_out_err_nxt = 1'b0;
                end else begin
                    w_dcnt_nxt = r_dcnt + DCW'(1);
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_in_ready_nxt  = (w_state_nxt == S_IDLE);
        w_out_valid_nxt = (w_state_nxt == S_OUT);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_gcd_start <= 1'b0;
            r_num       <= '0;
            r_den       <= '0;
            r_g         <= '0;
            r_wcnt      <= '0;
            r_dcnt      <= '0;
            r_rem_n     <= '0;
            r_rem_d     <= '0;
            r_q_n       <= '0;
            r_q_d       <= '0;
            r_out_num   <= '0;
            r_out_den   <= '0;
            r_out_gcd   <= '0;
            r_out_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_gcd_start <= w_gcd_start_nxt;
            r_num       <= w_num_nxt;
            r_den       <= w_den_nxt;
            r_g         <= w_g_nxt;
            r_wcnt      <= w_wcnt_nxt;
            r_dcnt      <= w_dcnt_nxt;
            r_rem_n     <= w_rem_n_nxt;
            r_rem_d     <= w_rem_d_nxt;
            r_q_n       <= w_q_n_nxt;
            r_q_d       <= w_q_d_nxt;
            r_out_num   <= w_out_num_nxt;
            r_out_den   <= w_out_den_nxt;
            r_out_gcd   <= w_out_gcd_nxt;
            r_out_err   <= w_out_err_nxt;
        end
    end

endmodule

// File: tb/tb_frac_reduce.sv
// Scoreboard bench for frac_reduce with a behavioural GCD core model.
module tb_frac_reduce;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned TIMEOUT = 255;

    typedef struct packed {
        logic [WIDTH-1:0] num;
        logic [WIDTH-1:0] den;
        logic [WIDTH-1:0] gcd;
        logic             err;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_num;
    logic [WIDTH-1:0] in_den;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_num;
    logic [WIDTH-1:0] out_den;
    logic [WIDTH-1:0] out_gcd;
    logic             out_err;
    logic [WIDTH-1:0] gcd_opa;
    logic [WIDTH-1:0] gcd_opb;
    logic             gcd_start;
    logic [WIDTH-1:0] gcd_result;
    logic             gcd_done;

    frac_reduce #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_num(in_num), .in_den(in_den),
        .out_valid(out_valid), .out_ready(out_ready), .out_num(out_num),
        .out_den(out_den), .out_gcd(out_gcd), .out_err(out_err),
        .gcd_opa(gcd_opa), .gcd_opb(gcd_opb), .gcd_start(gcd_start),
        .gcd_result(gcd_result), .gcd_done(gcd_done)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural Euclid core: done idles high, falls after start, rises after a delay
    function automatic logic [WIDTH-1:0] gcd_of(input logic [WIDTH-1:0] a_in, input logic [WIDTH-1:0] b_in);
        logic [WIDTH-1:0] a, b, t;
        a = a_in;
        b = b_in;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    logic             core_hang = 1'b0;
    int               core_cnt  = 0;
    logic [WIDTH-1:0] core_res  = '0;

    always @(posedge clk) begin
        if (reset) begin
            gcd_done   <= 1'b1;
            gcd_result <= '0;
            core_cnt   <= 0;
        end else if (gcd_start) begin
            gcd_done <= 1'b0;
            core_res <= core_hang ? WIDTH'(77) : gcd_of(gcd_opa, gcd_opb);
            core_cnt <= core_hang ? 270 : 4 + int'(gcd_opa[2:0]);
        end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) begin
                gcd_done   <= 1'b1;
                gcd_result <= core_res;
            end
        end
    end

    // Event timestamps used for latency checks
    int   t0 = 0, t_start = 0, t_done = 0, t_valid = 0;
    int   n_start = 0, n_done = 0;
    logic wait_done = 1'b0, prev_valid = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            wait_done  = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (gcd_start) begin
                t_start   = cyc;
                n_start++;
                wait_done = 1'b1;
            end else if (wait_done && gcd_done) begin
                t_done    = cyc;
                n_done++;
                wait_done = 1'b0;
            end
            if (out_valid && !prev_valid) t_valid = cyc;
            prev_valid = out_valid;
        end
    end

    // Monitor: drives out_ready with a programmable stall, checks stability and scoreboard
    int   stall_len = 0;
    int   hold      = 0;
    int   n_out     = 0;
    logic held_v    = 1'b0;
    exp_t held;
    exp_t e;

    always @(negedge clk) begin
        if (reset) begin
            out_ready = 1'b0;
            hold      = 0;
            held_v    = 1'b0;
        end else if (out_valid) begin
            chk("in_ready_low_while_out_valid", WIDTH'(in_ready), WIDTH'(0));
            if (held_v) begin
                chk("stall_stable_num", out_num, held.num);
                chk("stall_stable_den", out_den, held.den);
                chk("stall_stable_gcd", out_gcd, held.gcd);
                chk("stall_stable_err", WIDTH'(out_err), WIDTH'(held.err));
            end
            held.num = out_num;
            held.den = out_den;
            held.gcd = out_gcd;
            held.err = out_err;
            held_v   = 1'b1;
            if (hold >= stall_len) begin
                out_ready = 1'b1;
                hold      = 0;
                held_v    = 1'b0;
                n_out++;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0h/%0h expected no output", out_num, out_den);
                end else begin
                    e = sb_q.pop_front();
                    chk("out_num", out_num, e.num);
                    chk("out_den", out_den, e.den);
                    chk("out_gcd", out_gcd, e.gcd);
                    chk("out_err", WIDTH'(out_err), WIDTH'(e.err));
                end
            end else begin
                out_ready = 1'b0;
                hold++;
            end
        end else begin
            out_ready = 1'b0;
            held_v    = 1'b0;
        end
    end

    task automatic issue(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] d,
                         input logic [WIDTH-1:0] en, input logic [WIDTH-1:0] ed,
                         input logic [WIDTH-1:0] eg, input logic ee, input bit push);
        int   b;
        exp_t x;
        b = 0;
        @(negedge clk);
        while (!in_ready && b < 2000) begin
            @(negedge clk);
            b++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_wait: got in_ready=0 expected 1 within 2000 cycles");
        end else begin
            if (push) begin
                x.num = en;
                x.den = ed;
                x.gcd = eg;
                x.err = ee;
                sb_q.push_back(x);
            end
            in_num   = n;
            in_den   = d;
            in_valid = 1'b1;
            t0       = cyc;
            @(negedge clk);
            in_valid = 1'b0;
            in_num   = $urandom;
            in_den   = $urandom;
        end
    endtask

    task automatic wait_out(input int n);
        int b;
        b = 0;
        while (n_out < n && b < 3000) begin
            @(negedge clk);
            b++;
        end
        #1;
        if (n_out < n) begin
            checks++;
            errors++;
            $display("FAIL wait_output: got %0d results expected %0d", n_out, n);
        end
    endtask

    int ns;
    int lat;
    int b;

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_num   = '0;
        in_den   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", WIDTH'(in_ready), WIDTH'(1));
        chk("rst_out_valid", WIDTH'(out_valid), WIDTH'(0));
        chk("rst_gcd_start", WIDTH'(gcd_start), WIDTH'(0));
        chk("rst_out_num", out_num, '0);
        chk("rst_out_den", out_den, '0);
        chk("rst_out_gcd", out_gcd, '0);
        chk("rst_out_err", WIDTH'(out_err), WIDTH'(0));
        chk("rst_gcd_opa", gcd_opa, '0);
        chk("rst_gcd_opb", gcd_opb, '0);
        reset = 1'b0;

        // Basic reduction with latency checks
        issue(12, 18, 2, 3, 6, 1'b0, 1'b1);
        wait_out(1);
        chk("start_in_cycle1", WIDTH'(t_start - t0), WIDTH'(1));
        chk("valid_after_done", WIDTH'(t_valid - t_done), WIDTH'(WIDTH + 1));

        // Zero operands never reach the core
        ns = n_start;
        issue(0, 5, 0, 1, 5, 1'b0, 1'b1);
        wait_out(2);
        chk("zero_path_latency", WIDTH'(t_valid - t0), WIDTH'(1));
        issue(7, 0, 7, 0, 0, 1'b1, 1'b1);
        issue(0, 0, 0, 0, 0, 1'b1, 1'b1);
        wait_out(4);
        chk("zero_no_start", WIDTH'(n_start - ns), WIDTH'(0));

        // Boundary operands
        issue(17, 17, 1, 1, 17, 1'b0, 1'b1);
        issue(32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 1, 1, 1'b0, 1'b1);
        issue(1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 1, 1'b0, 1'b1);
        wait_out(7);

        // Back-to-back jobs with a stalled consumer
        stall_len = 10;
        issue(6, 4, 3, 2, 2, 1'b0, 1'b1);
        issue(35, 49, 5, 7, 7, 1'b0, 1'b1);
        issue(100, 75, 4, 3, 25, 1'b0, 1'b1);
        wait_out(10);

        // Core never answers in time; its late done lands while the result is stalled
        core_hang = 1'b1;
        stall_len = 20;
        issue(5, 3, 5, 3, 0, 1'b1, 1'b1);
        wait_out(11);
        lat = t_valid - t0;
        checks++;
        if (lat < int'(TIMEOUT) + 1 || lat > int'(TIMEOUT) + 3) begin
            errors++;
            $display("FAIL timeout_latency: got %0d expected %0d +-1", lat, TIMEOUT + 2);
        end
        core_hang = 1'b0;
        stall_len = 0;
        issue(9, 6, 3, 2, 3, 1'b0, 1'b1);
        wait_out(12);

        // Reset in the middle of the divide phase discards the job
        ns = n_done;
        issue(12, 18, 0, 0, 0, 1'b0, 1'b0);
        b = 0;
        while (n_done == ns && b < 500) begin
            @(negedge clk);
            b++;
        end
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", WIDTH'(out_valid), WIDTH'(0));
        chk("midrst_in_ready", WIDTH'(in_ready), WIDTH'(1));
        chk("midrst_gcd_start", WIDTH'(gcd_start), WIDTH'(0));
        reset = 1'b0;
        issue(8, 12, 2, 3, 4, 1'b0, 1'b1);
        wait_out(13);

        repeat (60) @(negedge clk);
        chk("scoreboard_empty", WIDTH'(sb_q.size()), WIDTH'(0));
        chk("output_count", WIDTH'(n_out), WIDTH'(13));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
